sr_sched: RTL

SR_SCHED -- requirements
Module: sr_sched

---
 rtl/sr_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sr_sched.sv
// sr_sched: accepts one configuration word, drives it into a shift-register engine and optionally reads it back to verify.
// Latency: the word is accepted in IDLE and WRITE starts next cycle; done pulses one cycle after the final sr_load edge, CHECK or timeout.
// Backpressure: req_ready is high only in IDLE, so req_valid while busy is ignored. Macro SR_READBACK_EN enables VERIFY/CHECK with retries.
module sr_sched #(
    parameter int WIDTH     = 170,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic             sr_start,
    output logic [WIDTH-1:0] sr_din,
    input  logic             sr_load,
    input  logic [WIDTH-1:0] sr_dout,
    output logic             done,
    output logic             pass,
    output logic             timeout_err,
    output logic [3:0]       retry_cnt,
    output logic             busy
);

`ifdef SR_READBACK_EN
    typedef enum logic [2:0] {IDLE, WRITE, VERIFY, CHECK, DONE} state_t;
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
`else
    typedef enum logic [2:0] {IDLE, WRITE, DONE} state_t;
    // Without readback, the chain output and retry limit have no consumer.
    logic unused_readback;
    assign unused_readback = ^{sr_dout, 4'(MAX_RETRY)};
`endif

    // Last cycle in WRITE/VERIFY before giving up on the engine.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        load_q;
    logic        load_edge;
    logic [15:0] cnt;
    logic        cnt_hit;
    logic        accept, fin_pass, fin_fail, fin_to, retry_inc;

    assign load_edge = sr_load & ~load_q;
    assign cnt_hit   = (cnt == TO_LAST);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
`ifdef SR_READBACK_EN
    assign sr_start  = (state == WRITE) || (state == VERIFY);
`else
    assign sr_start  = (state == WRITE);
`endif

    // Next-state and one-cycle control strobes for the result registers.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fin_pass  = 1'b0;
        fin_fail  = 1'b0;
        fin_to    = 1'b0;
        retry_inc = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (load_edge) begin
`ifdef SR_READBACK_EN
                    state_nxt = VERIFY;
`else
                    fin_pass  = 1'b1;
                    state_nxt = DONE;
`endif
                end else if (cnt_hit) begin
                    fin_to    = 1'b1;
                    state_nxt = DONE;
                end
            end
`ifdef SR_READBACK_EN
            VERIFY: begin
                if (load_edge) begin
                    state_nxt = CHECK;
                end else if (cnt_hit) begin
                    fin_to    = 1'b1;
                    state_nxt = DONE;
                end
            end
            CHECK: begin
                if (sr_dout == sr_din) begin
                    fin_pass  = 1'b1;
                    state_nxt = DONE;
                end else if (retry_cnt < RETRY_MAX) begin
                    retry_inc = 1'b1;
                    state_nxt = VERIFY;
                end else begin
                    fin_fail  = 1'b1;
                    state_nxt = DONE;
                end
            end
`endif
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, load-edge history and per-state cycle counter (cleared on every state change).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            load_q <= 1'b0;
            cnt    <= 16'd0;
        end else begin
            state  <= state_nxt;
            load_q <= sr_load;
            if (sr_start && (state_nxt == state))
                cnt <= cnt + 16'd1;
            else
                cnt <= 16'd0;
        end
    end

    // Request word and result registers: cleared at acceptance, then held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_din      <= '0;
            pass        <= 1'b0;
            timeout_err <= 1'b0;
            retry_cnt   <= 4'd0;
        end else begin
            if (accept) begin
                sr_din      <= req_data;
                pass        <= 1'b0;
                timeout_err <= 1'b0;
                retry_cnt   <= 4'd0;
            end
            if (fin_pass)
                pass <= 1'b1;
            if (fin_fail)
                pass <= 1'b0;
            if (fin_to) begin
                pass        <= 1'b0;
                timeout_err <= 1'b1;
            end
            if (retry_inc)
                retry_cnt <= retry_cnt + 4'd1;
        end
    end

endmodule
